// File: rtl/scsp_eg_multi_pkg.sv
// Shared types and rate helpers for the time-multiplexed SCSP envelope generator.
// Optional monitor readback port is enabled by defining SCSP_EG_MON_EN.
package scsp_eg_multi_pkg;

  localparam int unsigned EG_RATE_W    = 6;
  localparam int unsigned EG_INC_W     = 6;
  localparam int unsigned EG_CNT_LO_W  = 12;
  localparam int unsigned EG_ATT_W_MAX = 16;

  typedef enum logic [1:0] {
    EG_ATTACK  = 2'd0,
    EG_DECAY1  = 2'd1,
    EG_DECAY2  = 2'd2,
    EG_RELEASE = 2'd3
  } EGState_t;

  typedef struct packed {
    logic [EG_ATT_W_MAX-1:0] att;
    EGState_t                st;
  } EGSlotState_t;

  typedef struct packed {
    logic                 step;
    logic [EG_INC_W-1:0]  inc;
  } eg_step_t;

  // Per-update slot parameters captured by stage 1.
  typedef struct packed {
    logic       kon;
    logic       koff;
    logic [4:0] ar;
    logic [4:0] d1r;
    logic [4:0] d2r;
    logic [4:0] rr;
    logic [4:0] dl;
    logic [3:0] krs;
    logic [3:0] oct;
    logic       fns9;
    logic       eghold;
    logic       lpslnk;
    logic       loop_hit;
  } eg_req_t;

  function automatic logic [EG_RATE_W-1:0] EGRateCalc(
    input logic [4:0] rsel,
    input logic [3:0] krs,
    input logic [3:0] oct,
    input logic       fns9
  );
    logic signed [7:0] r;
    if (rsel == 5'd0)
      r = 8'sd0;
    else if (krs == 4'hF)
      r = $signed({2'b00, rsel, 1'b0});
    else
      r = $signed({4'b0000, krs}) + $signed({7'b0000000, fns9}) +
          $signed({2'b00, rsel, 1'b0}) + $signed({4'b0000, oct ^ 4'h8}) - 8'sd8;
    if (r < 8'sd0)
      return '0;
    else if (r > 8'sd60)
      return EG_RATE_W'(60);
    else
      return r[EG_RATE_W-1:0];
  endfunction

  function automatic eg_step_t EGStep(
    input logic [EG_RATE_W-1:0]   r,
    input logic [EG_CNT_LO_W-1:0] cnt
  );
    eg_step_t                res;
    logic [3:0]              h;
    logic [3:0]              s;
    logic [EG_CNT_LO_W-1:0]  mask;
    logic [EG_INC_W-1:0]     base;
    h        = r[5:2];
    s        = (h >= 4'd12) ? 4'd0 : 4'd12 - h;
    mask     = EG_CNT_LO_W'((13'd1 << s) - 13'd1);
    base     = EG_INC_W'(4) + EG_INC_W'(r[1:0]);
    res.step = (r != '0) && ((cnt & mask) == '0);
    res.inc  = (h >= 4'd12) ? EG_INC_W'(base << (h - 4'd12)) : EG_INC_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/scsp_eg_multi_state_ram.sv
// Per-slot {ST, ATT} storage with write-through synchronous read.
// Second (monitor) read port exists only when SCSP_EG_MON_EN is defined.
module scsp_eg_state_ram #(
  parameter int unsigned   DEPTH   = 32,
  parameter int unsigned   DW      = 12,
  parameter logic [DW-1:0] RST_VAL = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata
`ifdef SCSP_EG_MON_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] i_mon_addr,
  output logic [DW-1:0]            o_mon_rdata
`endif
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= RST_VAL;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A same-cycle write to the read slot is forwarded so back-to-back updates chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rdata <= RST_VAL;
    else if (i_re)
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

`ifdef SCSP_EG_MON_EN
  logic [DW-1:0] r_mon_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mon_rdata <= RST_VAL;
    else if (i_re)
      r_mon_rdata <= (i_we && (i_waddr == i_mon_addr)) ? i_wdata : r_mem[i_mon_addr];
  end

  assign o_mon_rdata = r_mon_rdata;
`endif

endmodule

// File: rtl/scsp_eg_multi.sv
// Time-multiplexed ADSR envelope generator: one slot read-modify-write per valid strobe.
// Define SCSP_EG_MON_EN to add the MON_SLOT/MON_ATT/MON_ST readback port.
module scsp_eg_multi
  import scsp_eg_multi_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 32,
  parameter int unsigned ATT_W     = 10,
  parameter int unsigned CNT_W     = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_ce,
  input  logic                         i_sample_stb,
  input  logic                         i_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_slot,
  input  logic                         i_kon,
  input  logic                         i_koff,
  input  logic [4:0]                   i_ar,
  input  logic [4:0]                   i_d1r,
  input  logic [4:0]                   i_d2r,
  input  logic [4:0]                   i_rr,
  input  logic [4:0]                   i_dl,
  input  logic [3:0]                   i_krs,
  input  logic [3:0]                   i_oct,
  input  logic                         i_fns9,
  input  logic                         i_eghold,
  input  logic                         i_lpslnk,
  input  logic                         i_loop_hit,
  output logic                         o_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] o_slot,
  output logic [ATT_W-1:0]             o_att,
  output EGState_t                     o_st,
  output logic                         o_idle
`ifdef SCSP_EG_MON_EN
  ,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_mon_slot,
  output logic [4:0]                   o_mon_att,
  output EGState_t                     o_mon_st
`endif
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned DW     = ATT_W + 2;
  localparam int unsigned PROD_W = ATT_W + 6;
  localparam int unsigned SUM_W  = ATT_W + 1;
  localparam logic [ATT_W-1:0] ATT_MAX = '1;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_s1_valid;
  logic [SLOT_W-1:0] r_s1_slot;
  eg_req_t           r_s1_req;
  logic [CNT_W-1:0]  r_s1_cnt;
  eg_req_t           w_req;
  logic [DW-1:0]     w_rd_data;

  logic              r_out_valid;
  logic [SLOT_W-1:0] r_out_slot;
  logic [ATT_W-1:0]  r_out_att;
  EGState_t          r_out_st;
  logic              r_out_idle;

  logic [ATT_W-1:0]     w_att;
  EGState_t             w_st;
  logic [4:0]           w_rsel;
  logic [EG_RATE_W-1:0] w_rate;
  eg_step_t             w_step;
  logic [PROD_W-1:0]    w_prod;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_we;

  assign w_req = '{kon: i_kon, koff: i_koff, ar: i_ar, d1r: i_d1r, d2r: i_d2r, rr: i_rr,
                   dl: i_dl, krs: i_krs, oct: i_oct, fns9: i_fns9, eghold: i_eghold,
                   lpslnk: i_lpslnk, loop_hit: i_loop_hit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_ce && i_sample_stb)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Stage 1: capture request and the counter value it is gated against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_slot  <= '0;
      r_s1_req   <= '0;
      r_s1_cnt   <= '0;
    end else if (i_ce) begin
      r_s1_valid <= i_valid;
      r_s1_slot  <= i_slot;
      r_s1_req   <= w_req;
      r_s1_cnt   <= r_cnt;
    end
  end

  assign w_we = i_ce && r_s1_valid;

  scsp_eg_state_ram #(
    .DEPTH   (NUM_SLOTS),
    .DW      (DW),
    .RST_VAL ({EG_RELEASE, {ATT_W{1'b1}}})
  ) u_state_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_re        (i_ce),
    .i_raddr     (i_slot),
    .o_rdata     (w_rd_data),
    .i_we        (w_we),
    .i_waddr     (r_s1_slot),
    .i_wdata     ({w_st, w_att})
`ifdef SCSP_EG_MON_EN
    ,
    .i_mon_addr  (i_mon_slot),
    .o_mon_rdata (w_mon_rdata)
`endif
  );

`ifdef SCSP_EG_MON_EN
  logic [DW-1:0] w_mon_rdata;
  assign o_mon_att = w_mon_rdata[ATT_W-1 -: 5];
  assign o_mon_st  = EGState_t'(w_mon_rdata[DW-1:ATT_W]);
`endif

  // Stage 2: key events, rate gating and per-state attenuation update.
  always_comb begin
    w_att  = w_rd_data[ATT_W-1:0];
    w_st   = EGState_t'(w_rd_data[DW-1:ATT_W]);
    w_rsel = 5'd0;
    w_rate = '0;
    w_step = '0;
    w_prod = '0;
    w_sum  = '0;
    if (r_s1_req.koff) begin
      w_st = EG_RELEASE;
    end else begin
      if (r_s1_req.kon) begin
        w_st = EG_ATTACK;
        if (r_s1_req.eghold) w_att = '0;
      end
      case (w_st)
        EG_ATTACK: w_rsel = r_s1_req.ar;
        EG_DECAY1: w_rsel = r_s1_req.d1r;
        EG_DECAY2: w_rsel = r_s1_req.d2r;
        default:   w_rsel = r_s1_req.rr;
      endcase
      w_rate = EGRateCalc(w_rsel, r_s1_req.krs, r_s1_req.oct, r_s1_req.fns9);
      w_step = EGStep(w_rate, EG_CNT_LO_W'(r_s1_cnt));
      if (w_st == EG_ATTACK) begin
        w_prod = (PROD_W'(w_att >> 4) + PROD_W'(1)) * PROD_W'(w_step.inc);
        if (w_step.step)
          w_att = (w_prod >= PROD_W'(w_att)) ? '0 : ATT_W'(PROD_W'(w_att) - w_prod);
        // Loop-linked slots hold in attack until the phase generator reaches LSA.
        if (r_s1_req.lpslnk ? r_s1_req.loop_hit : (w_att == '0))
          w_st = EG_DECAY1;
      end else begin
        w_sum = SUM_W'(w_att) + SUM_W'(w_step.inc);
        if (w_step.step)
          w_att = w_sum[ATT_W] ? ATT_MAX : w_sum[ATT_W-1:0];
        if ((w_st == EG_DECAY1) && (w_att[ATT_W-1 -: 5] >= r_s1_req.dl))
          w_st = EG_DECAY2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_slot  <= '0;
      r_out_att   <= ATT_MAX;
      r_out_st    <= EG_RELEASE;
      r_out_idle  <= 1'b1;
    end else if (i_ce) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_slot <= r_s1_slot;
        r_out_att  <= w_att;
        r_out_st   <= w_st;
        r_out_idle <= (w_st == EG_RELEASE) && (w_att == ATT_MAX);
      end
    end
  end

  assign o_valid = r_out_valid;
  assign o_slot  = r_out_slot;
  assign o_att   = r_out_att;
  assign o_st    = r_out_st;
  assign o_idle  = r_out_idle;

endmodule

// File: tb/tb_scsp_eg_multi.sv
// Randomised bench for scsp_eg_multi against a sequential per-slot envelope model.
// Monitor ports are connected only when SCSP_EG_MON_EN is defined.
module tb_scsp_eg_multi;
  import scsp_eg_multi_pkg::*;

  localparam int NS      = 32;
  localparam int SW      = 5;
  localparam int AW      = 10;
  localparam int ATT_MAX = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_ce = 0, i_sample_stb = 0, i_valid = 0;
  logic [SW-1:0] i_slot = '0;
  logic          i_kon = 0, i_koff = 0, i_fns9 = 0, i_eghold = 0, i_lpslnk = 0, i_loop_hit = 0;
  logic [4:0]    i_ar = '0, i_d1r = '0, i_d2r = '0, i_rr = '0, i_dl = '0;
  logic [3:0]    i_krs = '0, i_oct = '0;
  logic          o_valid, o_idle;
  logic [SW-1:0] o_slot;
  logic [AW-1:0] o_att;
  EGState_t      o_st;
`ifdef SCSP_EG_MON_EN
  logic [SW-1:0] i_mon_slot = '0;
  logic [4:0]    o_mon_att;
  EGState_t      o_mon_st;
`endif

  scsp_eg_multi #(.NUM_SLOTS(NS), .ATT_W(AW), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .i_ce(i_ce), .i_sample_stb(i_sample_stb),
    .i_valid(i_valid), .i_slot(i_slot), .i_kon(i_kon), .i_koff(i_koff),
    .i_ar(i_ar), .i_d1r(i_d1r), .i_d2r(i_d2r), .i_rr(i_rr), .i_dl(i_dl),
    .i_krs(i_krs), .i_oct(i_oct), .i_fns9(i_fns9), .i_eghold(i_eghold),
    .i_lpslnk(i_lpslnk), .i_loop_hit(i_loop_hit),
    .o_valid(o_valid), .o_slot(o_slot), .o_att(o_att), .o_st(o_st), .o_idle(o_idle)
`ifdef SCSP_EG_MON_EN
    , .i_mon_slot(i_mon_slot), .o_mon_att(o_mon_att), .o_mon_st(o_mon_st)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: slot contents, sample count, and the two-update output delay.
  EGSlotState_t m_slot [NS];
  int           m_cnt;
  bit           p_v;
  int           p_slot;
  EGSlotState_t p_state;
  bit           e_v;
  int           e_slot;
  EGSlotState_t e_state;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("o_valid", int'(o_valid), int'(e_v));
    chk("o_slot", int'(o_slot), e_slot);
    chk("o_att", int'(o_att), int'(e_state.att));
    chk("o_st", int'(o_st), int'(e_state.st));
    chk("o_idle", int'(o_idle), int'(e_state.st == EG_RELEASE && int'(e_state.att) == ATT_MAX));
  end

  function automatic int rate_of(input int rsel, input int krs, input int oct, input int fns9);
    int r;
    if (rsel == 0) return 0;
    if (krs == 15) r = 2 * rsel;
    else r = krs + fns9 + 2 * rsel + (oct ^ 8) - 8;
    if (r < 0) r = 0;
    if (r > 60) r = 60;
    return r;
  endfunction

  function automatic void model_apply(input int slot, input eg_req_t rq, input int cnt);
    int att, r, h, s, inc, rsel;
    bit stp;
    EGState_t st;
    att = int'(m_slot[slot].att);
    st  = m_slot[slot].st;
    if (rq.koff) begin
      st = EG_RELEASE;
    end else begin
      if (rq.kon) begin
        st = EG_ATTACK;
        if (rq.eghold) att = 0;
      end
      rsel = (st == EG_ATTACK) ? int'(rq.ar) : (st == EG_DECAY1) ? int'(rq.d1r) :
             (st == EG_DECAY2) ? int'(rq.d2r) : int'(rq.rr);
      r   = rate_of(rsel, int'(rq.krs), int'(rq.oct), int'(rq.fns9));
      h   = r / 4;
      s   = (h >= 12) ? 0 : 12 - h;
      stp = (r != 0) && ((cnt % (1 << s)) == 0);
      inc = (h >= 12) ? (4 + r % 4) * (1 << (h - 12)) : 1;
      if (st == EG_ATTACK) begin
        if (stp) begin
          att = att - (att / 16 + 1) * inc;
          if (att < 0) att = 0;
        end
        if (rq.lpslnk ? rq.loop_hit : (att == 0)) st = EG_DECAY1;
      end else begin
        if (stp) begin
          att = att + inc;
          if (att > ATT_MAX) att = ATT_MAX;
        end
        if (st == EG_DECAY1 && att / 32 >= int'(rq.dl)) st = EG_DECAY2;
      end
    end
    m_slot[slot].att = 16'(att);
    m_slot[slot].st  = st;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_slot[i].att = 16'(ATT_MAX);
      m_slot[i].st  = EG_RELEASE;
    end
    m_cnt = 0;
    p_v = 0; p_slot = 0; p_state = m_slot[0];
    e_v = 0; e_slot = 0; e_state = m_slot[0];
  endfunction

  // Called just after a negedge; drives one cycle and returns at the next negedge.
  task automatic tick(input bit v, input int slot, input eg_req_t rq, input bit stb, input bit ce);
    #2;
    i_valid = v; i_slot = SW'(slot); i_sample_stb = stb; i_ce = ce;
    i_kon = rq.kon; i_koff = rq.koff; i_ar = rq.ar; i_d1r = rq.d1r; i_d2r = rq.d2r;
    i_rr = rq.rr; i_dl = rq.dl; i_krs = rq.krs; i_oct = rq.oct; i_fns9 = rq.fns9;
    i_eghold = rq.eghold; i_lpslnk = rq.lpslnk; i_loop_hit = rq.loop_hit;
    if (ce) begin
      e_v = p_v;
      if (p_v) begin
        e_slot  = p_slot;
        e_state = p_state;
      end
      p_v = v;
      if (v) begin
        model_apply(slot, rq, m_cnt);
        p_slot  = slot;
        p_state = m_slot[slot];
      end
      if (stb) m_cnt = (m_cnt + 1) % 4096;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 0; i_ce = 0; i_valid = 0; i_sample_stb = 0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  function automatic eg_req_t rand_req();
    eg_req_t rq;
    rq.kon      = ($urandom_range(0, 15) == 0);
    rq.koff     = ($urandom_range(0, 15) == 0);
    rq.ar       = 5'($urandom_range(0, 31));
    rq.d1r      = 5'($urandom_range(0, 31));
    rq.d2r      = 5'($urandom_range(0, 31));
    rq.rr       = 5'($urandom_range(0, 31));
    rq.dl       = 5'($urandom_range(0, 31));
    rq.krs      = 4'($urandom_range(0, 15));
    rq.oct      = 4'($urandom_range(0, 15));
    rq.fns9     = 1'($urandom_range(0, 1));
    rq.eghold   = ($urandom_range(0, 3) == 0);
    rq.lpslnk   = ($urandom_range(0, 3) == 0);
    rq.loop_hit = 1'($urandom_range(0, 1));
    return rq;
  endfunction

  task automatic rand_phase(input int n);
    int slot;
    for (int k = 0; k < n; k++) begin
      slot = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(8, 10));
      tick($urandom_range(0, 3) != 0, slot, rand_req(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) != 0);
    end
  endtask

  eg_req_t rq;
  eg_req_t idle_rq;

  initial begin
    idle_rq = '0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_att", int'(o_att), 1023);
    chk("rst_idle", int'(o_idle), 1);

    // Slot 0 with all rates zero stays silent in release.
    tick(1, 0, idle_rq, 0, 1);
    tick(0, 0, idle_rq, 0, 1);
    chk("t1_valid", int'(o_valid), 1);
    chk("t1_att", int'(o_att), 1023);
    chk("t1_st", int'(o_st), int'(EG_RELEASE));
    chk("t1_idle", int'(o_idle), 1);

    // Fastest attack reaches zero and moves to decay 1 in one update.
    rq = '0; rq.kon = 1; rq.ar = 31; rq.krs = 4'hF;
    tick(1, 3, rq, 0, 1);
    tick(0, 0, idle_rq, 0, 1);
    chk("t2_att", int'(o_att), 0);
    chk("t2_st", int'(o_st), int'(EG_DECAY1));
    chk("t2_slot", int'(o_slot), 3);

    // Loop-linked attack holds at zero until LOOP_HIT.
    rq = '0; rq.kon = 1; rq.eghold = 1; rq.lpslnk = 1; rq.ar = 5; rq.krs = 4'hF;
    tick(1, 5, rq, 0, 1);
    rq.kon = 0;
    for (int k = 0; k < 10; k++) tick(1, 5, rq, 0, 1);
    tick(0, 0, idle_rq, 0, 1);
    chk("t3_hold_att", int'(o_att), 0);
    chk("t3_hold_st", int'(o_st), int'(EG_ATTACK));
    rq.loop_hit = 1;
    tick(1, 5, rq, 0, 1);
    tick(0, 0, idle_rq, 0, 1);
    chk("t3_st", int'(o_st), int'(EG_DECAY1));

    // Slot 7 walked to 120 in decay 1, then one 32-step crosses DL = 4.
    rq = '0; rq.kon = 1; rq.ar = 31; rq.krs = 4'hF;
    tick(1, 7, rq, 0, 1);
    rq = '0; rq.d1r = 26; rq.krs = 4'hF; rq.dl = 31;
    for (int k = 0; k < 15; k++) tick(1, 7, rq, 0, 1);
    chk("t4_pre_att", int'(m_slot[7].att), 120);
    chk("t4_pre_st", int'(m_slot[7].st), int'(EG_DECAY1));
    rq.d1r = 31; rq.dl = 4;
    tick(1, 7, rq, 0, 1);
    tick(0, 0, idle_rq, 0, 1);
    chk("t4_att", int'(o_att), 152);
    chk("t4_st", int'(o_st), int'(EG_DECAY2));

    // Slot 2: attack to 767, KON+KOFF together releases, RR = 0 freezes ATT.
    rq = '0; rq.kon = 1; rq.ar = 24; rq.krs = 4'hF;
    tick(1, 2, rq, 0, 1);
    chk("t5_attack_att", int'(m_slot[2].att), 767);
    rq = '0; rq.kon = 1; rq.koff = 1; rq.krs = 4'hF;
    tick(1, 2, rq, 0, 1);
    rq = '0; rq.krs = 4'hF;
    for (int k = 0; k < 1000; k++) tick((k % 50) == 0, 2, rq, 1, 1);
    tick(1, 2, rq, 0, 1);
    tick(0, 0, idle_rq, 0, 1);
    chk("t5_att", int'(o_att), 767);
    chk("t5_st", int'(o_st), int'(EG_RELEASE));

    // Slot 9 at 0x300 in release, two back-to-back RR = 31 updates.
    rq = '0; rq.kon = 1; rq.ar = 31; rq.krs = 4'hF;
    tick(1, 9, rq, 0, 1);
    rq = '0; rq.d1r = 31; rq.krs = 4'hF; rq.dl = 31;
    for (int k = 0; k < 24; k++) tick(1, 9, rq, 0, 1);
    rq = '0; rq.koff = 1;
    tick(1, 9, rq, 0, 1);
    chk("t6_pre_att", int'(m_slot[9].att), 'h300);
    rq = '0; rq.rr = 31; rq.krs = 4'hF;
    tick(1, 9, rq, 0, 1);
    tick(1, 9, rq, 0, 1);
    chk("t6_first", int'(o_att), 'h320);
    tick(0, 0, idle_rq, 0, 1);
    chk("t6_second", int'(o_att), 'h340);

    rand_phase(1500);
    do_reset();
    chk("midrst_att", int'(o_att), 1023);
    chk("midrst_valid", int'(o_valid), 0);
    rand_phase(1500);
    tick(0, 0, idle_rq, 0, 1);
    tick(0, 0, idle_rq, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scsp_eg_multi.md
Name: scsp_eg_multi

Overview:
- Parametrised, time-multiplexed envelope generator (EG) for the SCSP slot engine.
- Keeps per-slot ADSR state and attenuation in internal storage for NUM_SLOTS slots.
- Each valid slot strobe performs one read-modify-write of that slot's envelope.
- Attenuation width, slot count and the key-rate/loop-link behaviour are generalised beyond the fixed 32-slot, 10-bit EG.

Parameters:
- NUM_SLOTS, 32, number of slots; power of two, range 2..64.
- ATT_W, 10, attenuation width in bits; 0 = full volume, all-ones = silent; minimum 6.
- CNT_W, 12, width of the sample counter used for rate gating.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; when low, all state is frozen.
- SAMPLE_STB  in  1  one pulse per output sample; increments the sample counter.
- IN_VALID  in  1  slot parameters below are valid this cycle.
- IN_SLOT  in  log2(NUM_SLOTS)  slot index.
- KON / KOFF  in  1 / 1  key-on / key-off event for IN_SLOT.
- AR, D1R, D2R, RR  in  5 each  rates.
- DL  in  5  decay level.
- KRS  in  4  key rate scale.
- OCT  in  4  octave.
- FNS9  in  1  FNS[9].
- EGHOLD  in  1  attack hold.
- LPSLNK  in  1  loop-start link enable.
- LOOP_HIT  in  1  phase generator has passed LSA for IN_SLOT.
- OUT_VALID  out  1  result valid.
- OUT_SLOT  out  log2(NUM_SLOTS)  slot of the result.
- OUT_ATT  out  ATT_W  new attenuation.
- OUT_ST  out  2  EGState_t after the update.
- OUT_IDLE  out  1  ST = RELEASE and ATT = all-ones.

Behaviour:
- Reset, asynchronous, RST_N low:
  - every slot ATT = all-ones, ST = RELEASE;
  - sample counter = 0;
  - OUT_VALID = 0, OUT_SLOT = 0, OUT_ATT = all-ones, OUT_ST = RELEASE, OUT_IDLE = 1;
  - reset mid-operation discards in-flight pipeline entries.
- Pipeline, all stages advance only when CE = 1:
  - Stage 1 registers the inputs and reads the slot's state.
  - Stage 2 computes and writes back, and registers the outputs.
  - Latency: IN_VALID at cycle t gives OUT_VALID at t+2.
  - Throughput: one slot per cycle.
- Hazard: if stage 2 writes slot N in the same cycle stage 1 reads slot N, stage 1 uses the stage-2 result (forwarding). Back-to-back updates of the same slot must match two sequential updates.
- Sample counter: CNT_W-bit, wraps, increments on SAMPLE_STB & CE.
- Effective rate R, 6 bits, computed by EGRateCalc(Rsel, KRS, OCT, FNS9):
  - Rsel = 0 gives R = 0;
  - KRS = F gives R = 2*Rsel;
  - otherwise R = KRS + FNS9 + 2*Rsel + (OCT^8) - 8;
  - negative clamps to 0; any result above 60 clamps to 60.
- Step gate and increment:
  - H = R[5:2]; S = (H ≥ 12) ? 0 : 12 - H.
  - A step occurs iff R ≠ 0 and (cnt & ((1<<S)-1)) == 0.
  - INC = (H ≥ 12) ? ((4 + R[1:0]) << (H - 12)) : 1.
- State machine, evaluated on every valid update; priority is KOFF > KON > normal progress:
  - KOFF: go to RELEASE, ATT unchanged this update.
  - KON: go to ATTACK; if EGHOLD, ATT = 0.
  - ATTACK, Rsel = AR: on a step, ATT -= ((ATT>>4)+1)*INC, saturating at 0.
    - Leave when ATT = 0, evaluated after the update, going to DECAY1.
    - Exception: if LPSLNK = 1, leave only on LOOP_HIT = 1 (ATT stays at 0 until then).
  - DECAY1, Rsel = D1R: on a step, ATT += INC, saturating at all-ones.
    - Go to DECAY2 when ATT[ATT_W-1:ATT_W-5] ≥ DL, evaluated after the update.
  - DECAY2, Rsel = D2R: on a step, ATT += INC, saturating. No exit except KOFF or KON.
  - RELEASE, Rsel = RR: on a step, ATT += INC, saturating. No exit except KON.
  - KON and KOFF together: KOFF wins.
- Arithmetic: attack product width ATT_W+6, then saturate. Increments are computed at ATT_W+1 bits, then clamped.
- IN_VALID = 0: no write, OUT_VALID = 0 next stage; other outputs hold their values.

Optional Feature:
- Macro SCSP_EG_MON_EN.
- Defined: adds ports MON_SLOT (in, log2 NUM_SLOTS), MON_ATT (out, 5), MON_ST (out, 2).
  - One cycle after MON_SLOT is applied, these give the top 5 bits of ATT and the state of that slot, for CR4 EG readback.
  - Stage-2 writes to the same slot are forwarded.
  - Reset values: MON_ATT = 5'h1F, MON_ST = RELEASE.
- Undefined: these ports are absent, and no second read port is inferred.

Decomposition:
- Shared package SCSP_PKG gains:
  - EGRateCalc function;
  - EGStep function, returning the step flag and INC from R and cnt;
  - EGSlotState_t struct {ATT, ST}.
- It reuses the existing EGState_t.
- One sub-module, scsp_eg_state_ram: NUM_SLOTS × (ATT_W+2) storage, one synchronous read port and one write port; a second read port only under SCSP_EG_MON_EN.

Test Plan:
1. Reset, then IN_VALID for slot 0 with all rates 0 → OUT_ATT = 10'h3FF, OUT_ST = RELEASE, OUT_IDLE = 1 at t+2.
2. Slot 3: KON, AR = 31, KRS = F (R = 60, INC = 32) → OUT_ATT = 0 and OUT_ST = DECAY1 on the first update (ATT clamped at 0, leaves ATTACK).
3. Slot 5: KON, EGHOLD = 1, LPSLNK = 1, LOOP_HIT = 0 → ATT = 0, ST stays ATTACK over 10 updates. LOOP_HIT = 1 → ST = DECAY1.
4. Slot 7 in DECAY1 at ATT = 120, D1R = 31, KRS = F, DL = 4 → next update ATT = 152, ST = DECAY2 (top bits 4 ≥ 4).
5. Slot 2 in ATTACK, KOFF and KON in the same strobe, RR = 0 → ST = RELEASE, ATT unchanged across 1000 sample strobes.
6. Slot 9 valid on two consecutive cycles, RR = 31, KRS = F, starting from ATT = 10'h300 → outputs 10'h320 then 10'h340 (forwarding correct).
